// File: rtl/bram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bram_pkg
// Brief    : Shared types and helpers for the byte-enable single-port RAM.
// Revision : 1.0
// ============================================================================
package bram_pkg;

    typedef enum logic [1:0] {
        RDW_READ_FIRST,
        RDW_WRITE_FIRST,
        RDW_NO_CHANGE
    } rdw_mode_e;

    typedef enum logic [0:0] {
        CLR_CLEAR,
        CLR_RUN
    } clr_state_e;

    function automatic int bytes_of(input int width);
        return width / 8;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bram_clear_fsm.sv
`default_nettype none
// ============================================================================
// Module   : bram_clear_fsm
// Brief    : Post-reset sequencer that walks every word address once.
// Revision : 1.0
// ============================================================================
module bram_clear_fsm
    import bram_pkg::*;
#(
    parameter int ADDR_W         = 14,
    parameter int DEPTH          = 2**ADDR_W,
    parameter int CLEAR_ON_RESET = 0
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              busy_o,
    output logic [ADDR_W-1:0] clr_addr_o
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam clr_state_e        RESET_STATE = (CLEAR_ON_RESET != 0) ? CLR_CLEAR : CLR_RUN;

    clr_state_e        state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              busy_q;

    // busy tracks the state register, so it drops on the edge of the last clear write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
            busy_q  <= (CLEAR_ON_RESET != 0);
        end else if (state_q == CLR_CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_q <= CLR_RUN;
                busy_q  <= 1'b0;
            end
        end
    end

    assign busy_o     = busy_q;
    assign clr_addr_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/bram_sp_be.sv
`default_nettype none
// ============================================================================
// Module   : bram_sp_be
// Brief    : Single-port block RAM with byte enables, selectable
//            read-during-write mode, optional output stage and clear.
// Revision : 1.0
// ============================================================================
module bram_sp_be
    import bram_pkg::*;
#(
    parameter int        DATA_W         = 32,
    parameter int        ADDR_W         = 14,
    parameter int        DEPTH          = 2**ADDR_W,
    parameter rdw_mode_e RDW_MODE       = RDW_READ_FIRST,
    parameter int        OUT_REG        = 0,
    parameter string     INIT_FILE      = "",
    parameter int        CLEAR_ON_RESET = 0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic [DATA_W/8-1:0] we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   di,
    output logic [DATA_W-1:0]   dout,
    output logic                rvalid,
    output logic                busy
);

    localparam int NB = bytes_of(DATA_W);

    logic [DATA_W-1:0] mem_q [0:DEPTH-1];
    logic [DATA_W-1:0] rd_q;
    logic              rv1_q;
    logic              hit1_q;

    logic              busy_w;
    logic [ADDR_W-1:0] clr_addr_w;
    logic              acc_w;
    logic              in_range_w;
    logic              rd_fire_w;
    logic [ADDR_W-1:0] wr_addr_w;
    logic [NB-1:0]     wr_be_w;
    logic [DATA_W-1:0] wr_data_w;
    logic [DATA_W-1:0] dout1_w;

    bram_clear_fsm #(
        .ADDR_W         (ADDR_W),
        .DEPTH          (DEPTH),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clear (
        .clk        (clk),
        .rstn       (rstn),
        .busy_o     (busy_w),
        .clr_addr_o (clr_addr_w)
    );

    assign acc_w      = en && !busy_w;
    assign in_range_w = 32'(addr) < 32'(DEPTH);
    assign rd_fire_w  = acc_w && ((RDW_MODE != RDW_NO_CHANGE) || (we == '0));

    // The clear sequencer owns the single write port while busy
    always_comb begin
        wr_addr_w = addr;
        wr_data_w = di;
        wr_be_w   = '0;
        if (busy_w) begin
            wr_addr_w = clr_addr_w;
            wr_data_w = '0;
            wr_be_w   = '1;
        end else if (acc_w && in_range_w) begin
            wr_be_w = we;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wr_be_w[i]) begin
                mem_q[wr_addr_w][8*i +: 8] <= wr_data_w[8*i +: 8];
            end
            if (rd_fire_w) begin
                if ((RDW_MODE == RDW_WRITE_FIRST) && we[i]) begin
                    rd_q[8*i +: 8] <= di[8*i +: 8];
                end else begin
                    rd_q[8*i +: 8] <= mem_q[addr][8*i +: 8];
                end
            end
        end
    end

    // hit1_q masks rd_q to zero after reset and for out-of-range reads
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rv1_q  <= 1'b0;
            hit1_q <= 1'b0;
        end else begin
            rv1_q <= rd_fire_w;
            if (rd_fire_w) begin
                hit1_q <= in_range_w;
            end
        end
    end

    assign dout1_w = hit1_q ? rd_q : '0;

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] dout2_q;
            logic              rv2_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    dout2_q <= '0;
                    rv2_q   <= 1'b0;
                end else begin
                    rv2_q <= rv1_q;
                    if (rv1_q) begin
                        dout2_q <= dout1_w;
                    end
                end
            end

            assign dout   = dout2_q;
            assign rvalid = rv2_q;
        end else begin : g_no_out_reg
            assign dout   = dout1_w;
            assign rvalid = rv1_q;
        end
    endgenerate

    assign busy = busy_w;

endmodule
`default_nettype wire

// File: tb/tb_bram_sp_be.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_sp_be
// Brief    : Self-checking bench driving six RAM configurations side by side.
// Revision : 1.0
// ============================================================================
module tb_bram_sp_be;
    import bram_pkg::*;

    localparam int NDUT = 6;

    function automatic rdw_mode_e cfg_mode(input int n);
        case (n)
            1, 5:    return RDW_WRITE_FIRST;
            2:       return RDW_NO_CHANGE;
            default: return RDW_READ_FIRST;
        endcase
    endfunction
    function automatic int cfg_out(input int n);
        return (n == 3 || n == 5) ? 1 : 0;
    endfunction
    function automatic int cfg_depth(input int n);
        return (n == 5) ? 12 : 16;
    endfunction
    function automatic int cfg_clr(input int n);
        return (n == 4) ? 1 : 0;
    endfunction

    logic        clk;
    logic        rstn_s   [NDUT];
    logic        en_s     [NDUT];
    logic [3:0]  we_s     [NDUT];
    logic [3:0]  addr_s   [NDUT];
    logic [31:0] di_s     [NDUT];
    logic [31:0] dout_s   [NDUT];
    logic        rvalid_s [NDUT];
    logic        busy_s   [NDUT];

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        bram_sp_be #(
            .DATA_W         (32),
            .ADDR_W         (4),
            .DEPTH          (cfg_depth(g)),
            .RDW_MODE       (cfg_mode(g)),
            .OUT_REG        (cfg_out(g)),
            .INIT_FILE      (""),
            .CLEAR_ON_RESET (cfg_clr(g))
        ) u_dut (
            .clk    (clk),
            .rstn   (rstn_s[g]),
            .en     (en_s[g]),
            .we     (we_s[g]),
            .addr   (addr_s[g]),
            .di     (di_s[g]),
            .dout   (dout_s[g]),
            .rvalid (rvalid_s[g]),
            .busy   (busy_s[g])
        );
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    logic [31:0] mm  [NDUT][16];
    bit          mk  [NDUT][16];   // word content is known to the model
    int          busy_left [NDUT];
    logic [31:0] s1d [NDUT], s2d [NDUT];
    bit          s1v [NDUT], s2v [NDUT], s1k [NDUT], s2k [NDUT];

    initial begin
        for (int n = 0; n < NDUT; n++)
            for (int a = 0; a < 16; a++) mk[n][a] = 0;
    end

    always @(posedge clk) begin
        logic [31:0] old, mrg;
        bit inr, kn_old, kn_mrg;
        int a;
        for (int n = 0; n < NDUT; n++) begin
            if (!rstn_s[n]) begin
                busy_left[n] = cfg_clr(n) ? cfg_depth(n) : 0;
                s1d[n] = 0; s2d[n] = 0; s1v[n] = 0; s2v[n] = 0; s1k[n] = 1; s2k[n] = 1;
            end else begin
                if (s1v[n]) begin s2d[n] = s1d[n]; s2k[n] = s1k[n]; end
                s2v[n] = s1v[n];
                s1v[n] = 0;
                if (busy_left[n] > 0) begin
                    mm[n][cfg_depth(n) - busy_left[n]] = 0;
                    mk[n][cfg_depth(n) - busy_left[n]] = 1;
                    busy_left[n]--;
                end else if (en_s[n]) begin
                    a      = int'(addr_s[n]);
                    inr    = a < cfg_depth(n);
                    old    = inr ? mm[n][a] : 32'h0;
                    kn_old = inr ? mk[n][a] : 1'b1;
                    mrg    = old;
                    for (int i = 0; i < 4; i++)
                        if (we_s[n][i]) mrg[8*i +: 8] = di_s[n][8*i +: 8];
                    kn_mrg = kn_old || (we_s[n] == 4'hF);
                    if (inr && we_s[n] != 0) begin
                        mm[n][a] = mrg;
                        mk[n][a] = kn_mrg;
                    end
                    case (cfg_mode(n))
                        RDW_READ_FIRST: begin
                            s1v[n] = 1; s1d[n] = old; s1k[n] = kn_old;
                        end
                        RDW_WRITE_FIRST: begin
                            s1v[n] = 1; s1d[n] = inr ? mrg : 32'h0; s1k[n] = inr ? kn_mrg : 1'b1;
                        end
                        default: begin
                            if (we_s[n] == 0) begin
                                s1v[n] = 1; s1d[n] = old; s1k[n] = kn_old;
                            end
                        end
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int n = 0; n < NDUT; n++) begin
                check($sformatf("rvalid[%0d]", n), 32'(rvalid_s[n]),
                      32'(cfg_out(n) != 0 ? s2v[n] : s1v[n]));
                check($sformatf("busy[%0d]", n), 32'(busy_s[n]), 32'(busy_left[n] > 0));
                if (cfg_out(n) != 0 ? s2k[n] : s1k[n])
                    check($sformatf("dout[%0d]", n), dout_s[n], cfg_out(n) != 0 ? s2d[n] : s1d[n]);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drv(input int n, input logic e, input logic [3:0] w,
                       input logic [3:0] a, input logic [31:0] d);
        en_s[n] = e; we_s[n] = w; addr_s[n] = a; di_s[n] = d;
    endtask
    task automatic idle();
        for (int n = 0; n < NDUT; n++) en_s[n] = 1'b0;
    endtask
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int rv_cnt;
        for (int n = 0; n < NDUT; n++) begin
            rstn_s[n] = 0; en_s[n] = 0; we_s[n] = 0; addr_s[n] = 0; di_s[n] = 0;
        end
        repeat (3) tick();
        chk_on = 1;
        check("rst_dout", dout_s[0], 32'h0);
        check("rst_rvalid", 32'(rvalid_s[3]), 32'h0);
        check("rst_busy_clr", 32'(busy_s[4]), 32'h1);
        check("rst_busy_noclr", 32'(busy_s[0]), 32'h0);
        #1;
        for (int n = 0; n < NDUT; n++) rstn_s[n] = 1;

        // clear window: requests on the clearing RAM must be dropped
        c = 0;
        do begin
            drv(4, 1'b1, 4'hF, 4'($urandom), $urandom | 32'h1);
            tick();
            c++;
        end while (busy_s[4] && c < 64);
        check("clr_cycles", c, 16);

        for (int a = 0; a < 16; a++) begin
            idle();
            for (int n = 0; n < NDUT; n++)
                if (n != 4) drv(n, 1'b1, 4'hF, 4'(a), $urandom);
            drv(4, 1'b1, 4'h0, 4'(a), 32'h0);
            tick();
            check("clr_zero", dout_s[4], 32'h0);
        end
        idle(); tick(); tick();

        // read-first: old word returned on overwrite
        drv(0, 1, 4'hF, 4'd5, 32'hDEADBEEF); tick(); idle();
        drv(0, 1, 4'hF, 4'd5, 32'h12345678); tick(); idle();
        check("rf_old_dout", dout_s[0], 32'hDEADBEEF);
        check("rf_old_rvalid", 32'(rvalid_s[0]), 32'h1);
        drv(0, 1, 4'h0, 4'd5, 32'h0); tick(); idle();
        check("rf_new_dout", dout_s[0], 32'h12345678);

        // write-first partial lanes
        drv(1, 1, 4'hF, 4'd3, 32'hAABBCCDD); tick(); idle();
        drv(1, 1, 4'b0101, 4'd3, 32'h11223344); tick(); idle();
        check("wf_merge_dout", dout_s[1], 32'hAA22CC44);
        drv(1, 1, 4'h0, 4'd3, 32'h0); tick(); idle();
        check("wf_merge_ram", dout_s[1], 32'hAA22CC44);

        // no-change: a write keeps dout and gives no rvalid
        drv(2, 1, 4'hF, 4'd7, 32'h7); tick(); idle();
        drv(2, 1, 4'h0, 4'd7, 32'h0); tick(); idle();
        check("nc_read_dout", dout_s[2], 32'h7);
        check("nc_read_rvalid", 32'(rvalid_s[2]), 32'h1);
        drv(2, 1, 4'hF, 4'd8, 32'h88); tick(); idle();
        check("nc_write_dout", dout_s[2], 32'h7);
        check("nc_write_rvalid", 32'(rvalid_s[2]), 32'h0);

        // output-register streaming
        for (int a = 0; a < 3; a++) begin
            drv(3, 1, 4'hF, 4'(a), 32'h100 + 32'(a)); tick(); idle();
        end
        tick(); tick();
        rv_cnt = 0;
        drv(3, 1, 4'h0, 4'd0, 32'h0); tick(); idle();
        check("or_lat_rvalid", 32'(rvalid_s[3]), 32'h0);
        drv(3, 1, 4'h0, 4'd1, 32'h0); tick(); idle();
        rv_cnt += int'(rvalid_s[3]);
        check("or_d0", dout_s[3], 32'h100);
        drv(3, 1, 4'h0, 4'd2, 32'h0); tick(); idle();
        rv_cnt += int'(rvalid_s[3]);
        check("or_d1", dout_s[3], 32'h101);
        tick();
        rv_cnt += int'(rvalid_s[3]);
        check("or_d2", dout_s[3], 32'h102);
        tick();
        rv_cnt += int'(rvalid_s[3]);
        check("or_hold", dout_s[3], 32'h102);
        check("or_rvalid_cnt", rv_cnt, 3);

        // out-of-range on a 12-word RAM
        drv(5, 1, 4'hF, 4'd13, 32'hFFFFFFFF); tick(); idle();
        drv(5, 1, 4'h0, 4'd13, 32'h0); tick(); idle();
        check("oor_wr_dout", dout_s[5], 32'h0);
        tick();
        check("oor_rd_dout", dout_s[5], 32'h0);
        check("oor_rd_rvalid", 32'(rvalid_s[5]), 32'h1);
        for (int a = 0; a < 12; a++) begin
            drv(5, 1, 4'h0, 4'(a), 32'h0); tick(); idle();
        end
        tick(); tick();

        // fill the clearing RAM, then reset it mid-clear
        for (int a = 0; a < 16; a++) begin
            drv(4, 1, 4'hF, 4'(a), 32'hA5A50001 + 32'(a)); tick(); idle();
        end
        tick();
        #1 rstn_s[4] = 0;
        tick();
        #1 rstn_s[4] = 1;
        repeat (9) tick();
        #1 rstn_s[4] = 0;
        tick();
        check("mid_busy", 32'(busy_s[4]), 32'h1);
        #1 rstn_s[4] = 1;
        c = 0;
        do begin
            drv(4, 1'b1, 4'hF, 4'($urandom), $urandom | 32'h1);
            tick();
            c++;
        end while (busy_s[4] && c < 64);
        check("clr_restart_cycles", c, 16);
        idle();
        for (int a = 0; a < 16; a++) begin
            drv(4, 1, 4'h0, 4'(a), 32'h0); tick(); idle();
            check("clr2_zero", dout_s[4], 32'h0);
        end

        // randomized traffic on every configuration
        repeat (1500) begin
            for (int n = 0; n < NDUT; n++)
                drv(n, ($urandom_range(0, 9) < 7),
                    ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0,
                    4'($urandom), $urandom);
            tick();
        end
        idle();
        repeat (4) tick();
        chk_on = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
